// File: rtl/bcd_sum_display.sv
// bcd_sum_display: captures a BCD digit-adder result and shows it on a
// 2-digit time-multiplexed common-anode 7-segment display.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   load      capture strobe for sum_in/carry_in
//   sum_in    adder sum; [3:0] is the units digit, [4] ignored
//   carry_in  adder carry; the tens digit (0 or 1)
//   seg       segments {g,f,e,d,c,b,a}, active-low, registered
//   an        anodes, active-low, an[0]=units, an[1]=tens, registered
//   valid     a value has been captured since reset
//   err       captured units digit is greater than 9
//
// Optional: define LEADING_ZERO_BLANK_EN to blank the tens digit when it is 0.
module bcd_sum_display #(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [4:0] sum_in,
    input  logic       carry_in,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       valid,
    output logic       err
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [1:0] AN_OFF  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        UNITS,
        TENS
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       units_r;
    logic             tens_r;
    logic [6:0]       seg_d;
    logic [1:0]       an_d;
    logic             wrap_c;

    // BCD to active-low segments; anything above 9 shows "E".
    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h06;
        endcase
    endfunction

    assign wrap_c = (cnt == CNT_MAX);

    // Free-running slot timer, independent of load and FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (wrap_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Capture of the adder result; last load wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            units_r <= 4'd0;
            tens_r  <= 1'b0;
            valid   <= 1'b0;
            err     <= 1'b0;
        end else if (load) begin
            units_r <= sum_in[3:0];
            tens_r  <= carry_in;
            valid   <= 1'b1;
            err     <= (sum_in[3:0] > 4'd9);
        end
    end

    // Digit-select state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and next display drive; the first BLANK_CYC counts of a slot stay dark.
    always_comb begin
        state_next = state;
        seg_d      = SEG_OFF;
        an_d       = AN_OFF;
        case (state)
            IDLE: begin
                if (valid && wrap_c) begin
                    state_next = UNITS;
                end
            end
            UNITS: begin
                if (wrap_c) begin
                    state_next = TENS;
                end
                if (cnt >= BLANK_END) begin
                    an_d  = 2'b10;
                    seg_d = decode(units_r);
                end
            end
            TENS: begin
                if (wrap_c) begin
                    state_next = UNITS;
                end
                if (cnt >= BLANK_END) begin
`ifdef LEADING_ZERO_BLANK_EN
                    if (tens_r) begin
                        an_d  = 2'b01;
                        seg_d = decode({3'b000, tens_r});
                    end
`else
                    an_d  = 2'b01;
                    seg_d = decode({3'b000, tens_r});
`endif
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= SEG_OFF;
            an  <= AN_OFF;
        end else begin
            seg <= seg_d;
            an  <= an_d;
        end
    end

endmodule
